// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I core: sequences fetch, decode,
// execute, memory and writeback over a shared ALU and a single memory.
module multicycle_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       zero,
    input  logic       neg,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [2:0] ImmSrc,
    output logic       RegWrite,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LUI      = 4'd12
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    state_t     r_state;
    state_t     w_next;
    logic       w_pc_update;
    logic       w_taken;
    logic [2:0] w_alu_funct;
    logic       w_unused;

    // Only funct7[5] (add/sub select) matters to this controller.
    assign w_unused = ^{funct7[6], funct7[4:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Shared funct3 map for register and immediate ALU ops; sub is applied in EXECR only.
    always_comb begin
        w_alu_funct = ALU_ADD;
        case (funct3)
            3'b111:  w_alu_funct = ALU_AND;
            3'b110:  w_alu_funct = ALU_OR;
            3'b100:  w_alu_funct = ALU_XOR;
            3'b010:  w_alu_funct = ALU_SLT;
            default: w_alu_funct = ALU_ADD;
        endcase
    end

    always_comb begin
        w_taken = 1'b0;
        case (funct3)
            3'b000:  w_taken = zero;
            3'b001:  w_taken = ~zero;
            3'b100:  w_taken = neg;
            3'b101:  w_taken = ~neg;
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_next      = S_FETCH;
        w_pc_update = 1'b0;
        AdrSrc      = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        ResultSrc   = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        ALUControl  = ALU_ADD;
        ImmSrc      = IMM_I;
        RegWrite    = 1'b0;
        case (r_state)
            S_FETCH: begin
                IRWrite     = 1'b1;
                ALUSrcB     = 2'b10;
                ResultSrc   = 2'b10;
                w_pc_update = 1'b1;
                w_next      = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = (op == OP_JAL) ? IMM_J : IMM_B;
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_R:         w_next = S_EXECR;
                    OP_I:         w_next = S_EXECI;
                    OP_BR:        w_next = S_BRANCH;
                    OP_JAL:       w_next = S_JAL;
                    OP_JALR:      w_next = S_JALR;
                    OP_LUI:       w_next = S_LUI;
                    default:      w_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ImmSrc  = (op == OP_SW) ? IMM_S : IMM_I;
                w_next  = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                w_next = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                w_next    = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                ImmSrc   = IMM_S;
                w_next   = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b00;
                ALUControl = (funct3 == 3'b000 && funct7[5]) ? ALU_SUB : w_alu_funct;
                w_next     = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ImmSrc     = IMM_I;
                ALUControl = w_alu_funct;
                w_next     = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                w_next   = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b00;
                ALUControl = ALU_SUB;
                ImmSrc     = IMM_B;
                w_next     = S_FETCH;
            end
            S_JAL: begin
                // PC takes the target held in ALUOut while the ALU forms OldPC+4.
                w_pc_update = 1'b1;
                ALUSrcA     = 2'b01;
                ALUSrcB     = 2'b10;
                ImmSrc      = IMM_J;
                w_next      = S_ALUWB;
            end
            S_JALR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ImmSrc  = IMM_I;
                w_next  = S_JAL;
            end
            S_LUI: begin
                ImmSrc    = IMM_U;
                ResultSrc = 2'b11;
                RegWrite  = 1'b1;
                w_next    = S_FETCH;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    assign PCWrite = w_pc_update | ((r_state == S_BRANCH) & w_taken);
    assign state   = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class
// through its state sequence and checks control outputs per state.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic [6:0] funct7 = 7'd0;
    logic       zero = 1'b0;
    logic       neg = 1'b0;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ALUControl, ImmSrc;
    logic [3:0] state;

    int n_checks = 0;
    int n_errors = 0;

    multicycle_controller dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7),
        .zero(zero), .neg(neg), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
        .ImmSrc(ImmSrc), .RegWrite(RegWrite), .state(state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_instr(input logic [6:0] o, input logic [2:0] f3,
                               input logic [6:0] f7, input logic z, input logic n);
        op = o; funct3 = f3; funct7 = f7; zero = z; neg = n;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (state !== 4'd0) begin n_errors++; $display("FAIL reset_state: got %0d expected 0", state); end
        n_checks++;
        if ({IRWrite, PCWrite, ALUSrcB, ResultSrc} !== 6'b11_10_10) begin
            n_errors++; $display("FAIL reset_fetch_outs: got %b expected 111010", {IRWrite, PCWrite, ALUSrcB, ResultSrc});
        end
        n_checks++;
        if ({MemWrite, RegWrite, AdrSrc, ALUSrcA, ALUControl, ImmSrc} !== 11'd0) begin
            n_errors++; $display("FAIL reset_zero_outs: got %b expected 0", {MemWrite, RegWrite, AdrSrc, ALUSrcA, ALUControl, ImmSrc});
        end
        drive_instr(7'b0000000, 3'd0, 7'd0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        n_checks++;
        if (state !== 4'd1) begin n_errors++; $display("FAIL reset_first_edge: got %0d expected 1", state); end
        tick();
    endtask

    task automatic test_rtype(input string name, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [2:0] exp_alu);
        logic [3:0] seq[$] = '{4'd0, 4'd1, 4'd6, 4'd8};
        int rw = 0;
        drive_instr(7'b0110011, f3, f7, 1'b0, 1'b0);
        for (int i = 0; i < seq.size(); i++) begin
            n_checks++;
            if (state !== seq[i]) begin n_errors++; $display("FAIL %s_state[%0d]: got %0d expected %0d", name, i, state, seq[i]); end
            if (i == 2) begin
                n_checks++;
                if ({ALUControl, ALUSrcA, ALUSrcB} !== {exp_alu, 2'b10, 2'b00}) begin
                    n_errors++; $display("FAIL %s_execr: got alu=%b srca=%b srcb=%b expected alu=%b srca=10 srcb=00", name, ALUControl, ALUSrcA, ALUSrcB, exp_alu);
                end
            end
            if (i == 3) begin
                n_checks++;
                if (RegWrite !== 1'b1) begin n_errors++; $display("FAIL %s_aluwb_regwrite: got %b expected 1", name, RegWrite); end
            end
            if (RegWrite === 1'b1) rw++;
            tick();
        end
        n_checks++;
        if (state !== 4'd0 || rw != 1) begin
            n_errors++; $display("FAIL %s_end: got state=%0d regwrites=%0d expected state=0 regwrites=1", name, state, rw);
        end
    endtask

    task automatic test_itype(input string name, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [2:0] exp_alu);
        logic [3:0] seq[$] = '{4'd0, 4'd1, 4'd7, 4'd8};
        drive_instr(7'b0010011, f3, f7, 1'b0, 1'b0);
        for (int i = 0; i < seq.size(); i++) begin
            n_checks++;
            if (state !== seq[i]) begin n_errors++; $display("FAIL %s_state[%0d]: got %0d expected %0d", name, i, state, seq[i]); end
            if (i == 2) begin
                n_checks++;
                if ({ALUControl, ALUSrcB, ImmSrc} !== {exp_alu, 2'b01, 3'b000}) begin
                    n_errors++; $display("FAIL %s_execi: got alu=%b srcb=%b imm=%b expected alu=%b srcb=01 imm=000", name, ALUControl, ALUSrcB, ImmSrc, exp_alu);
                end
            end
            tick();
        end
    endtask

    task automatic test_load_store();
        logic [3:0] lw_seq[$] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
        logic [3:0] sw_seq[$] = '{4'd0, 4'd1, 4'd2, 4'd5};
        int rw = 0;
        int mw = 0;
        drive_instr(7'b0000011, 3'b010, 7'd0, 1'b0, 1'b0);
        for (int i = 0; i < lw_seq.size(); i++) begin
            n_checks++;
            if (state !== lw_seq[i]) begin n_errors++; $display("FAIL lw_state[%0d]: got %0d expected %0d", i, state, lw_seq[i]); end
            if (i == 2) begin
                n_checks++;
                if (ImmSrc !== 3'b000) begin n_errors++; $display("FAIL lw_memadr_imm: got %b expected 000", ImmSrc); end
            end
            if (i == 3) begin
                n_checks++;
                if (AdrSrc !== 1'b1) begin n_errors++; $display("FAIL lw_memread_adrsrc: got %b expected 1", AdrSrc); end
            end
            if (i == 4) begin
                n_checks++;
                if ({RegWrite, ResultSrc} !== 3'b1_01) begin n_errors++; $display("FAIL lw_memwb: got %b expected 101", {RegWrite, ResultSrc}); end
            end
            if (RegWrite === 1'b1) rw++;
            if (MemWrite === 1'b1) mw++;
            tick();
        end
        n_checks++;
        if (rw != 1 || mw != 0) begin n_errors++; $display("FAIL lw_writes: got rw=%0d mw=%0d expected rw=1 mw=0", rw, mw); end

        rw = 0; mw = 0;
        drive_instr(7'b0100011, 3'b010, 7'd0, 1'b0, 1'b0);
        for (int i = 0; i < sw_seq.size(); i++) begin
            n_checks++;
            if (state !== sw_seq[i]) begin n_errors++; $display("FAIL sw_state[%0d]: got %0d expected %0d", i, state, sw_seq[i]); end
            if (i == 2) begin
                n_checks++;
                if (ImmSrc !== 3'b001) begin n_errors++; $display("FAIL sw_memadr_imm: got %b expected 001", ImmSrc); end
            end
            if (i == 3) begin
                n_checks++;
                if ({MemWrite, AdrSrc, ImmSrc} !== 5'b1_1_001) begin
                    n_errors++; $display("FAIL sw_memwrite: got %b expected 11001", {MemWrite, AdrSrc, ImmSrc});
                end
            end
            if (RegWrite === 1'b1) rw++;
            if (MemWrite === 1'b1) mw++;
            tick();
        end
        n_checks++;
        if (rw != 0 || mw != 1 || state !== 4'd0) begin
            n_errors++; $display("FAIL sw_writes: got rw=%0d mw=%0d state=%0d expected rw=0 mw=1 state=0", rw, mw, state);
        end
    endtask

    task automatic test_branches();
        logic [2:0] f3_v[4]  = '{3'b000, 3'b001, 3'b100, 3'b101};
        logic       z_v[4]   = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic       n_v[4]   = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic       exp_v[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 4; k++) begin
            drive_instr(7'b1100011, f3_v[k], 7'd0, z_v[k], n_v[k]);
            tick();
            tick();
            n_checks++;
            if (state !== 4'd9) begin n_errors++; $display("FAIL br%0d_state: got %0d expected 9", k, state); end
            n_checks++;
            if ({PCWrite, ALUControl, RegWrite, MemWrite} !== {exp_v[k], 3'b001, 2'b00}) begin
                n_errors++; $display("FAIL br%0d_outs: got pcw=%b alu=%b rw=%b mw=%b expected pcw=%b alu=001 rw=0 mw=0", k, PCWrite, ALUControl, RegWrite, MemWrite, exp_v[k]);
            end
            tick();
            n_checks++;
            if (state !== 4'd0) begin n_errors++; $display("FAIL br%0d_end: got %0d expected 0", k, state); end
        end
    endtask

    task automatic test_jumps();
        logic [3:0] jalr_seq[$] = '{4'd0, 4'd1, 4'd11, 4'd10, 4'd8};
        int pw = 0;
        drive_instr(7'b1100111, 3'b000, 7'd0, 1'b0, 1'b0);
        for (int i = 0; i < jalr_seq.size(); i++) begin
            n_checks++;
            if (state !== jalr_seq[i]) begin n_errors++; $display("FAIL jalr_state[%0d]: got %0d expected %0d", i, state, jalr_seq[i]); end
            if (i == 3) begin
                n_checks++;
                if ({PCWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc} !== {1'b1, 2'b00, 2'b01, 2'b10, 3'b011}) begin
                    n_errors++; $display("FAIL jalr_jal_outs: got pcw=%b res=%b srca=%b srcb=%b imm=%b expected 1 00 01 10 011", PCWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc);
                end
            end
            if (PCWrite === 1'b1) pw++;
            tick();
        end
        n_checks++;
        if (pw != 2) begin n_errors++; $display("FAIL jalr_pcwrites: got %0d expected 2", pw); end

        drive_instr(7'b1101111, 3'b000, 7'd0, 1'b0, 1'b0);
        tick();
        n_checks++;
        if (state !== 4'd1 || ImmSrc !== 3'b011) begin
            n_errors++; $display("FAIL jal_decode: got state=%0d imm=%b expected state=1 imm=011", state, ImmSrc);
        end
        tick();
        n_checks++;
        if (state !== 4'd10) begin n_errors++; $display("FAIL jal_state: got %0d expected 10", state); end
        tick();
        tick();
    endtask

    task automatic test_lui_illegal();
        drive_instr(7'b0110111, 3'b000, 7'd0, 1'b0, 1'b0);
        tick();
        tick();
        n_checks++;
        if ({state, ResultSrc, RegWrite, ImmSrc} !== {4'd12, 2'b11, 1'b1, 3'b100}) begin
            n_errors++; $display("FAIL lui_outs: got state=%0d res=%b rw=%b imm=%b expected 12 11 1 100", state, ResultSrc, RegWrite, ImmSrc);
        end
        tick();
        drive_instr(7'b0000000, 3'b000, 7'd0, 1'b0, 1'b0);
        tick();
        n_checks++;
        if ({state, RegWrite, MemWrite, PCWrite} !== {4'd1, 3'b000}) begin
            n_errors++; $display("FAIL nop_decode: got state=%0d rw=%b mw=%b pcw=%b expected 1 0 0 0", state, RegWrite, MemWrite, PCWrite);
        end
        tick();
        n_checks++;
        if (state !== 4'd0) begin n_errors++; $display("FAIL nop_end: got %0d expected 0", state); end
    endtask

    task automatic test_reset_mid();
        drive_instr(7'b0100011, 3'b010, 7'd0, 1'b0, 1'b0);
        repeat (3) tick();
        n_checks++;
        if (state !== 4'd5 || MemWrite !== 1'b1) begin
            n_errors++; $display("FAIL mid_pre: got state=%0d mw=%b expected 5 1", state, MemWrite);
        end
        #1 rst = 1'b0;
        #1;
        n_checks++;
        if (state !== 4'd0 || MemWrite !== 1'b0) begin
            n_errors++; $display("FAIL mid_async: got state=%0d mw=%b expected 0 0", state, MemWrite);
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
        n_checks++;
        if (state !== 4'd1) begin n_errors++; $display("FAIL mid_restart: got %0d expected 1", state); end
    endtask

    initial begin
        test_reset();
        test_rtype("add", 3'b000, 7'b0000000, 3'b000);
        test_rtype("sub", 3'b000, 7'b0100000, 3'b001);
        test_rtype("slt", 3'b010, 7'b0000000, 3'b101);
        test_rtype("and", 3'b111, 7'b0000000, 3'b010);
        test_itype("addi_f30", 3'b000, 7'b0100000, 3'b000);
        test_itype("xori", 3'b100, 7'b0000000, 3'b100);
        test_itype("ori", 3'b110, 7'b0000000, 3'b011);
        test_itype("bad_f3", 3'b001, 7'b0000000, 3'b000);
        test_load_store();
        test_branches();
        test_jumps();
        test_lui_illegal();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
